// File: rtl/rf_pkg.sv
// Shared constants for the configuration register file: reserved entry map,
// default reset values and UART_CFG field positions.
package rf_pkg;

  localparam int unsigned ALU_OP_A  = 0;
  localparam int unsigned ALU_OP_B  = 1;
  localparam int unsigned UART_CFG  = 2;
  localparam int unsigned DIV_RATIO = 3;

  localparam logic [15:0] RF_RST_VAL_2 = 16'h0081;
  localparam logic [15:0] RF_RST_VAL_3 = 16'h0020;

  localparam int unsigned PAR_EN_BIT   = 0;
  localparam int unsigned PAR_TYP_BIT  = 1;
  localparam int unsigned PRESCALE_LSB = 2;
  localparam int unsigned PRESCALE_MSB = 7;

endpackage

// File: rtl/reg_file_cfg_if.sv
// Read/write bus between the system controller and the register file.
interface reg_file_cfg_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 3
);
  logic                 WrEn;
  logic                 RdEn;
  logic [ADDR_W-1:0]    Address;
  logic [WIDTH-1:0]     WrData;
  logic [WIDTH/8-1:0]   WrStrb;
  logic [WIDTH-1:0]     RdData;
  logic                 RdData_Valid;
  logic                 Err;

  modport master (
    output WrEn, RdEn, Address, WrData, WrStrb,
    input  RdData, RdData_Valid, Err
  );

  modport slave (
    input  WrEn, RdEn, Address, WrData, WrStrb,
    output RdData, RdData_Valid, Err
  );
endinterface

// File: rtl/rf_strobe_merge.sv
// Byte-lane merge: each lane takes new data when its strobe is set, else keeps old.
module rf_strobe_merge #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0]   old_i,
  input  logic [WIDTH-1:0]   wdata_i,
  input  logic [WIDTH/8-1:0] strb_i,
  output logic [WIDTH-1:0]   merged_o
);
  localparam int unsigned NBYTES = WIDTH / 8;

  always_comb begin
    merged_o = old_i;
    for (int unsigned b = 0; b < NBYTES; b++) begin
      if (strb_i[b]) merged_o[8*b +: 8] = wdata_i[8*b +: 8];
    end
  end
endmodule

// File: rtl/reg_file_cfg.sv
// Flop-based configuration register file with byte strobes, registered read,
// error pulse and live taps of the four reserved entries.
module reg_file_cfg
  import rf_pkg::*;
#(
  parameter int unsigned      WIDTH     = 16,
  parameter int unsigned      DEPTH     = 8,
  parameter int unsigned      ADDR_W    = 3,
  parameter logic [WIDTH-1:0] RST_VAL_2 = WIDTH'(RF_RST_VAL_2),
  parameter logic [WIDTH-1:0] RST_VAL_3 = WIDTH'(RF_RST_VAL_3)
) (
  input  logic             CLK,
  input  logic             RST,
  reg_file_cfg_if.slave    bus,
  output logic [WIDTH-1:0] REG0,
  output logic [WIDTH-1:0] REG1,
  output logic [WIDTH-1:0] REG2,
  output logic [WIDTH-1:0] REG3
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             in_range_c;
  logic [WIDTH-1:0] old_c;
  logic [WIDTH-1:0] merged_c;

  // Address decode and current contents of the addressed entry
  always_comb begin
    in_range_c = 32'(bus.Address) < DEPTH;
    old_c      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (bus.Address == ADDR_W'(i)) old_c = mem_q[i];
    end
  end

  rf_strobe_merge #(.WIDTH(WIDTH)) u_merge (
    .old_i    (old_c),
    .wdata_i  (bus.WrData),
    .strb_i   (bus.WrStrb),
    .merged_o (merged_c)
  );

  // Next state: a collision blocks both operations; out-of-range reads still pulse valid
  always_comb begin
    mem_d   = mem_q;
    rdata_d = rdata_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (bus.WrEn && bus.RdEn) begin
      err_d = 1'b1;
    end else if (bus.WrEn) begin
      if (in_range_c) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (bus.Address == ADDR_W'(i)) mem_d[i] = merged_c;
        end
      end else begin
        err_d = 1'b1;
      end
    end else if (bus.RdEn) begin
      valid_d = 1'b1;
      if (in_range_c) begin
        rdata_d = old_c;
      end else begin
        rdata_d = '0;
        err_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= (i == UART_CFG)  ? RST_VAL_2 :
                    (i == DIV_RATIO) ? RST_VAL_3 : '0;
      end
      rdata_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign bus.RdData       = rdata_q;
  assign bus.RdData_Valid = valid_q;
  assign bus.Err          = err_q;

  assign REG0 = mem_q[ALU_OP_A];
  assign REG1 = mem_q[ALU_OP_B];
  assign REG2 = mem_q[UART_CFG];
  assign REG3 = mem_q[DIV_RATIO];
endmodule

// File: tb/tb_reg_file_cfg.sv
// Directed bench for reg_file_cfg: default instance plus a DEPTH=6 instance
// for out-of-range addressing.
module tb_reg_file_cfg;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 CLK = ~CLK;

  reg_file_cfg_if #(.WIDTH(16), .ADDR_W(3)) a_if ();
  reg_file_cfg_if #(.WIDTH(16), .ADDR_W(3)) b_if ();

  logic [15:0] a_reg0, a_reg1, a_reg2, a_reg3;
  logic [15:0] b_reg0, b_reg1, b_reg2, b_reg3;

  reg_file_cfg #(.WIDTH(16), .DEPTH(8), .ADDR_W(3)) u_dut_a (
    .CLK (CLK), .RST (RST), .bus (a_if.slave),
    .REG0 (a_reg0), .REG1 (a_reg1), .REG2 (a_reg2), .REG3 (a_reg3)
  );

  reg_file_cfg #(.WIDTH(16), .DEPTH(6), .ADDR_W(3)) u_dut_b (
    .CLK (CLK), .RST (RST), .bus (b_if.slave),
    .REG0 (b_reg0), .REG1 (b_reg1), .REG2 (b_reg2), .REG3 (b_reg3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_a(input logic wr, input logic rd, input logic [2:0] addr,
                         input logic [15:0] data, input logic [1:0] strb);
    a_if.WrEn    = wr;
    a_if.RdEn    = rd;
    a_if.Address = addr;
    a_if.WrData  = data;
    a_if.WrStrb  = strb;
  endtask

  task automatic drive_b(input logic wr, input logic rd, input logic [2:0] addr,
                         input logic [15:0] data, input logic [1:0] strb);
    b_if.WrEn    = wr;
    b_if.RdEn    = rd;
    b_if.Address = addr;
    b_if.WrData  = data;
    b_if.WrStrb  = strb;
  endtask

  logic [15:0] rst_exp [4];

  initial begin
    rst_exp[0] = 16'h0000;
    rst_exp[1] = 16'h0000;
    rst_exp[2] = 16'h0081;
    rst_exp[3] = 16'h0020;
    drive_a(1'b0, 1'b0, 3'd0, 16'h0000, 2'b00);
    drive_b(1'b0, 1'b0, 3'd0, 16'h0000, 2'b00);

    // Reset state
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("rst_rdata", 32'(a_if.RdData), 32'h0);
    chk("rst_valid", 32'(a_if.RdData_Valid), 32'h0);
    chk("rst_err",   32'(a_if.Err), 32'h0);
    chk("rst_reg0",  32'(a_reg0), 32'h0000);
    chk("rst_reg1",  32'(a_reg1), 32'h0000);
    chk("rst_reg2",  32'(a_reg2), 32'h0081);
    chk("rst_reg3",  32'(a_reg3), 32'h0020);

    // Back-to-back reads of the reserved entries
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b0, 1'b1, 3'(i), 16'h0000, 2'b00);
      step();
      chk($sformatf("rst_rd%0d_data", i), 32'(a_if.RdData), 32'(rst_exp[i]));
      chk($sformatf("rst_rd%0d_valid", i), 32'(a_if.RdData_Valid), 32'h1);
      chk($sformatf("rst_rd%0d_err", i), 32'(a_if.Err), 32'h0);
    end
    drive_a(1'b0, 1'b0, 3'd0, 16'h0000, 2'b00);
    step();
    chk("idle_valid", 32'(a_if.RdData_Valid), 32'h0);
    chk("idle_hold",  32'(a_if.RdData), 32'h0020);

    // Write then read address 5
    drive_a(1'b1, 1'b0, 3'd5, 16'h000A, 2'b11);
    step();
    chk("wr5_valid", 32'(a_if.RdData_Valid), 32'h0);
    chk("wr5_err",   32'(a_if.Err), 32'h0);
    drive_a(1'b0, 1'b1, 3'd5, 16'h0000, 2'b00);
    step();
    chk("rd5_data",  32'(a_if.RdData), 32'h000A);
    chk("rd5_valid", 32'(a_if.RdData_Valid), 32'h1);
    chk("rd5_err",   32'(a_if.Err), 32'h0);
    drive_a(1'b0, 1'b0, 3'd0, 16'h0000, 2'b00);
    step();
    chk("rd5_pulse_end", 32'(a_if.RdData_Valid), 32'h0);

    // Byte strobes on UART_CFG
    drive_a(1'b1, 1'b0, 3'd2, 16'hBEEF, 2'b10);
    step();
    chk("strb_hi_reg2", 32'(a_reg2), 32'hBE81);
    drive_a(1'b1, 1'b0, 3'd2, 16'h1234, 2'b00);
    step();
    chk("strb_none_reg2", 32'(a_reg2), 32'hBE81);
    chk("strb_none_err",  32'(a_if.Err), 32'h0);
    drive_a(1'b1, 1'b0, 3'd0, 16'h5A3C, 2'b01);
    step();
    chk("strb_lo_reg0", 32'(a_reg0), 32'h003C);

    // Collision at address 1
    drive_a(1'b1, 1'b1, 3'd1, 16'h1234, 2'b11);
    step();
    chk("coll_err",   32'(a_if.Err), 32'h1);
    chk("coll_valid", 32'(a_if.RdData_Valid), 32'h0);
    chk("coll_hold",  32'(a_if.RdData), 32'h000A);
    chk("coll_reg1",  32'(a_reg1), 32'h0000);
    drive_a(1'b0, 1'b0, 3'd0, 16'h0000, 2'b00);
    step();
    chk("coll_pulse_end", 32'(a_if.Err), 32'h0);

    // Out of range on the DEPTH=6 instance
    drive_b(1'b0, 1'b1, 3'd2, 16'h0000, 2'b00);
    step();
    chk("b_rd2_data", 32'(b_if.RdData), 32'h0081);
    drive_b(1'b1, 1'b0, 3'd7, 16'h5555, 2'b11);
    step();
    chk("oor_wr_err",   32'(b_if.Err), 32'h1);
    chk("oor_wr_valid", 32'(b_if.RdData_Valid), 32'h0);
    chk("oor_wr_reg0",  32'(b_reg0), 32'h0000);
    chk("oor_wr_reg1",  32'(b_reg1), 32'h0000);
    chk("oor_wr_reg2",  32'(b_reg2), 32'h0081);
    chk("oor_wr_reg3",  32'(b_reg3), 32'h0020);
    drive_b(1'b0, 1'b1, 3'd6, 16'h0000, 2'b00);
    step();
    chk("oor_rd_data",  32'(b_if.RdData), 32'h0);
    chk("oor_rd_valid", 32'(b_if.RdData_Valid), 32'h1);
    chk("oor_rd_err",   32'(b_if.Err), 32'h1);
    drive_b(1'b0, 1'b1, 3'd5, 16'h0000, 2'b00);
    step();
    chk("b_rd5_data", 32'(b_if.RdData), 32'h0000);
    chk("b_rd5_err",  32'(b_if.Err), 32'h0);
    drive_b(1'b0, 1'b0, 3'd0, 16'h0000, 2'b00);

    // Reset wins over a concurrent write
    drive_a(1'b1, 1'b0, 3'd3, 16'h00FF, 2'b11);
    RST = 1'b1;
    step();
    RST = 1'b0;
    drive_a(1'b0, 1'b0, 3'd0, 16'h0000, 2'b00);
    chk("rstwr_reg3",  32'(a_reg3), 32'h0020);
    chk("rstwr_reg2",  32'(a_reg2), 32'h0081);
    chk("rstwr_reg0",  32'(a_reg0), 32'h0000);
    chk("rstwr_rdata", 32'(a_if.RdData), 32'h0);
    chk("rstwr_valid", 32'(a_if.RdData_Valid), 32'h0);
    chk("rstwr_err",   32'(a_if.Err), 32'h0);
    step();
    chk("rstwr_after_reg3",  32'(a_reg3), 32'h0020);
    chk("rstwr_after_valid", 32'(a_if.RdData_Valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
